control_unit: RTL and testbench

//  Fetch/decode/execute sequencer for the 16-bit bus CPU; sits directly downstream of the

---
 rtl/cpu_pkg.sv | 59 +++++
 rtl/reg_sel_decoder.sv | 12 +
 rtl/control_unit.sv | 213 +++++++++++++++++++++
 tb/tb_control_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit bus CPU control path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    // Instruction opcodes, IR[15:12]. Opcodes 0..7 are R-type.
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_MOV = 4'd6;
    localparam logic [3:0] OP_CMP = 4'd7;
    localparam logic [3:0] OP_LDI = 4'd8;
    localparam logic [3:0] OP_LD  = 4'd9;
    localparam logic [3:0] OP_ST  = 4'd10;
    localparam logic [3:0] OP_JMP = 4'd11;
    localparam logic [3:0] OP_BZ  = 4'd12;
    localparam logic [3:0] OP_BN  = 4'd13;
    localparam logic [3:0] OP_NOP = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    // Memory wait budget; the counter width must hold MEM_WAIT_MAX.
    localparam int MEM_WAIT_MAX_DEF = 15;
    localparam int MEM_WAIT_W       = 4;

    typedef enum logic [3:0] {
        FETCH0, FETCH1, FETCH2, DECODE, EX0, EX1, EX2, HALT, FAULT
    } state_t;

    // One cycle's worth of control: bus/latch strobes plus register-file
    // selects (index + enable) and the ALU controls.
    typedef struct packed {
        logic       ir_in;
        logic       pc_in;
        logic       pc_out;
        logic       pc_inc;
        logic       mar_in;
        logic       mdr_in;
        logic       mdr_out;
        logic       y_in;
        logic       z_in;
        logic       z_out;
        logic       imm_out;
        logic       mem_read;
        logic       mem_write;
        logic       halt;
        logic       fault;
        logic       flags_in;
        logic       lat_en;
        logic [2:0] lat_idx;
        logic       drv_en;
        logic [2:0] drv_idx;
        logic [2:0] alu_op;
        logic [1:0] alu_shift;
    } ctl_t;

endpackage

// File: rtl/reg_sel_decoder.sv
// 3-bit register index to 8-bit one-hot select, gated by an enable.
// Latency: combinational. Backpressure: none.
// Ports: idx_i register index, en_i select enable, onehot_o one-hot (all zero when disabled).
module reg_sel_decoder (
    input  logic [2:0] idx_i,
    input  logic       en_i,
    output logic [7:0] onehot_o
);

    assign onehot_o = en_i ? (8'b0000_0001 << idx_i) : 8'b0000_0000;

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer driving the DATA-bus strobes, ALU, PC and memory handshake.
// Latency: 4 fetch/decode cycles + 1..3 execute cycles, plus memory wait cycles.
// Backpressure: stalls in FETCH1 / LD-EX1 / ST-EX2 until mem_ready; faults after MEM_WAIT_MAX waits.
// Ports: clk, reset (async active-low); IR fields opcode/S/shift/rd_1/rd_2/rs_1/rs_2; flag_z/flag_n;
//        mem_ready; strobe outputs; reg_latch/reg_enable one-hot; alu_op/alu_shift/flags_in;
//        mem_read/mem_write; halt; fault.
module control_unit
    import cpu_pkg::*;
#(
    parameter int MEM_WAIT_MAX = MEM_WAIT_MAX_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       S,
    input  logic [1:0] shift,
    input  logic [2:0] rd_1,
    input  logic [2:0] rd_2,
    input  logic [2:0] rs_1,
    input  logic [2:0] rs_2,
    input  logic       flag_z,
    input  logic       flag_n,
    input  logic       mem_ready,
    output logic       IR_in,
    output logic       PC_in,
    output logic       PC_out,
    output logic       PC_inc,
    output logic       MAR_in,
    output logic       MDR_in,
    output logic       MDR_out,
    output logic       Y_in,
    output logic       Z_in,
    output logic       Z_out,
    output logic       imm_out,
    output logic [7:0] reg_latch,
    output logic [7:0] reg_enable,
    output logic [2:0] alu_op,
    output logic [1:0] alu_shift,
    output logic       flags_in,
    output logic       mem_read,
    output logic       mem_write,
    output logic       halt,
    output logic       fault
);

    state_t                state_q, state_d;
    logic [MEM_WAIT_W-1:0] wait_q, wait_d;
    ctl_t                  ctl_c;     // raw decode of the current state
    ctl_t                  ctl_o;     // forced to zero while reset is held
    logic                  rtype;

    assign rtype = ~opcode[3];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        ctl_c   = '0;
        case (state_q)
            FETCH0: begin
                ctl_c.pc_out = 1'b1;
                ctl_c.mar_in = 1'b1;
                state_d      = FETCH1;
            end
            FETCH1: begin
                ctl_c.mem_read = 1'b1;
                if (mem_ready) begin
                    ctl_c.pc_inc = 1'b1;
                    state_d      = FETCH2;
                end
            end
            FETCH2: begin
                ctl_c.mdr_out = 1'b1;
                ctl_c.ir_in   = 1'b1;
                state_d       = DECODE;
            end
            DECODE: state_d = EX0;
            EX0: begin
                state_d = FETCH0;
                if (rtype) begin
                    ctl_c.drv_en  = 1'b1;
                    ctl_c.drv_idx = rs_1;
                    ctl_c.y_in    = 1'b1;
                    state_d       = EX1;
                end else begin
                    case (opcode)
                        OP_LDI: begin
                            ctl_c.imm_out = 1'b1;
                            ctl_c.lat_en  = 1'b1;
                            ctl_c.lat_idx = rd_2;
                        end
                        OP_LD, OP_ST: begin
                            ctl_c.drv_en  = 1'b1;
                            ctl_c.drv_idx = rs_2;
                            ctl_c.mar_in  = 1'b1;
                            state_d       = EX1;
                        end
                        // Flags come from the ALU flag register, which only updates in R-type EX1,
                        // so they are stable while a branch sits in EX0.
                        OP_JMP, OP_BZ, OP_BN: begin
                            if ((opcode == OP_JMP) || (opcode == OP_BZ && flag_z) ||
                                (opcode == OP_BN && flag_n)) begin
                                ctl_c.drv_en  = 1'b1;
                                ctl_c.drv_idx = rs_2;
                                ctl_c.pc_in   = 1'b1;
                            end
                        end
                        OP_HLT:  state_d = HALT;
                        default: state_d = FETCH0;   // NOP
                    endcase
                end
            end
            EX1: begin
                state_d = FETCH0;
                if (rtype) begin
                    ctl_c.drv_en    = 1'b1;
                    ctl_c.drv_idx   = rs_2;
                    ctl_c.alu_op    = opcode[2:0];
                    ctl_c.alu_shift = shift;
                    ctl_c.z_in      = 1'b1;
                    ctl_c.flags_in  = S | (opcode == OP_CMP);
                    state_d         = EX2;
                end else if (opcode == OP_LD) begin
                    ctl_c.mem_read = 1'b1;
                    state_d        = mem_ready ? EX2 : EX1;
                end else if (opcode == OP_ST) begin
                    ctl_c.drv_en  = 1'b1;
                    ctl_c.drv_idx = rd_2;
                    ctl_c.mdr_in  = 1'b1;
                    state_d       = EX2;
                end
            end
            EX2: begin
                state_d = FETCH0;
                if (rtype) begin
                    ctl_c.z_out   = 1'b1;
                    ctl_c.lat_en  = (opcode != OP_CMP);
                    ctl_c.lat_idx = rd_1;
                end else if (opcode == OP_LD) begin
                    ctl_c.mdr_out = 1'b1;
                    ctl_c.lat_en  = 1'b1;
                    ctl_c.lat_idx = rd_2;
                end else if (opcode == OP_ST) begin
                    ctl_c.mem_write = 1'b1;
                    state_d         = mem_ready ? FETCH0 : EX2;
                end
            end
            HALT: ctl_c.halt = 1'b1;
            FAULT: begin
                ctl_c.halt  = 1'b1;
                ctl_c.fault = 1'b1;
            end
            default: state_d = FETCH0;
        endcase

        // Wait counter only moves while a memory access is outstanding; mem_ready elsewhere
        // never reaches it. The last allowed wait cycle diverts to FAULT.
        if (ctl_c.mem_read || ctl_c.mem_write) begin
            if (mem_ready) begin
                wait_d = '0;
            end else begin
                wait_d = wait_q + MEM_WAIT_W'(1);
                if (wait_q == MEM_WAIT_W'(MEM_WAIT_MAX - 1)) begin
                    state_d = FAULT;
                end
            end
        end
    end

    // State is FETCH0 during reset, so outputs are blanked explicitly until release.
    assign ctl_o = reset ? ctl_c : '0;

    assign IR_in     = ctl_o.ir_in;
    assign PC_in     = ctl_o.pc_in;
    assign PC_out    = ctl_o.pc_out;
    assign PC_inc    = ctl_o.pc_inc;
    assign MAR_in    = ctl_o.mar_in;
    assign MDR_in    = ctl_o.mdr_in;
    assign MDR_out   = ctl_o.mdr_out;
    assign Y_in      = ctl_o.y_in;
    assign Z_in      = ctl_o.z_in;
    assign Z_out     = ctl_o.z_out;
    assign imm_out   = ctl_o.imm_out;
    assign mem_read  = ctl_o.mem_read;
    assign mem_write = ctl_o.mem_write;
    assign halt      = ctl_o.halt;
    assign fault     = ctl_o.fault;
    assign flags_in  = ctl_o.flags_in;
    assign alu_op    = ctl_o.alu_op;
    assign alu_shift = ctl_o.alu_shift;

    reg_sel_decoder u_latch_sel (
        .idx_i    (ctl_o.lat_idx),
        .en_i     (ctl_o.lat_en),
        .onehot_o (reg_latch)
    );

    reg_sel_decoder u_drive_sel (
        .idx_i    (ctl_o.drv_idx),
        .en_i     (ctl_o.drv_en),
        .onehot_o (reg_enable)
    );

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle strobe vectors against hand-computed values.
// Latency: n/a. Backpressure: mem_ready driven per cycle by the stimulus.
// Bus-exclusivity invariants are watched every cycle and reported once at the end.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic       S;
    logic [1:0] shift;
    logic [2:0] rd_1, rd_2, rs_1, rs_2;
    logic       flag_z, flag_n, mem_ready;
    logic       IR_in, PC_in, PC_out, PC_inc, MAR_in, MDR_in, MDR_out, Y_in, Z_in, Z_out, imm_out;
    logic [7:0] reg_latch, reg_enable;
    logic [2:0] alu_op;
    logic [1:0] alu_shift;
    logic       flags_in, mem_read, mem_write, halt, fault;
    logic [15:0] strb;

    int n_chk = 0;
    int n_err = 0;
    int viol  = 0;
    int cyc   = 0;
    int t0    = 0;

    localparam logic [15:0] M_IR_IN   = 16'h8000;
    localparam logic [15:0] M_PC_IN   = 16'h4000;
    localparam logic [15:0] M_PC_OUT  = 16'h2000;
    localparam logic [15:0] M_PC_INC  = 16'h1000;
    localparam logic [15:0] M_MAR_IN  = 16'h0800;
    localparam logic [15:0] M_MDR_IN  = 16'h0400;
    localparam logic [15:0] M_MDR_OUT = 16'h0200;
    localparam logic [15:0] M_Y_IN    = 16'h0100;
    localparam logic [15:0] M_Z_IN    = 16'h0080;
    localparam logic [15:0] M_Z_OUT   = 16'h0040;
    localparam logic [15:0] M_IMM_OUT = 16'h0020;
    localparam logic [15:0] M_MEM_RD  = 16'h0010;
    localparam logic [15:0] M_MEM_WR  = 16'h0008;
    localparam logic [15:0] M_HALT    = 16'h0004;
    localparam logic [15:0] M_FAULT   = 16'h0002;
    localparam logic [15:0] M_FLAGS   = 16'h0001;

    always #5 clk = ~clk;

    control_unit #(.MEM_WAIT_MAX(15)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .S(S), .shift(shift),
        .rd_1(rd_1), .rd_2(rd_2), .rs_1(rs_1), .rs_2(rs_2),
        .flag_z(flag_z), .flag_n(flag_n), .mem_ready(mem_ready),
        .IR_in(IR_in), .PC_in(PC_in), .PC_out(PC_out), .PC_inc(PC_inc), .MAR_in(MAR_in),
        .MDR_in(MDR_in), .MDR_out(MDR_out), .Y_in(Y_in), .Z_in(Z_in), .Z_out(Z_out),
        .imm_out(imm_out), .reg_latch(reg_latch), .reg_enable(reg_enable),
        .alu_op(alu_op), .alu_shift(alu_shift), .flags_in(flags_in),
        .mem_read(mem_read), .mem_write(mem_write), .halt(halt), .fault(fault)
    );

    assign strb = {IR_in, PC_in, PC_out, PC_inc, MAR_in, MDR_in, MDR_out, Y_in,
                   Z_in, Z_out, imm_out, mem_read, mem_write, halt, fault, flags_in};

    // Mid-cycle invariant watch: one bus driver at most, no read+write, no latch/drive overlap.
    always @(negedge clk) begin
        #2;
        if ((32'(PC_out) + 32'(MDR_out) + 32'(Z_out) + 32'(imm_out) + $countones(reg_enable)) > 1)
            viol++;
        if (mem_read && mem_write) viol++;
        if ((reg_latch & reg_enable) != 8'h00) viol++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        cyc++;
    endtask

    task automatic exp_cyc(input string tag, input logic [15:0] s,
                           input logic [7:0] l, input logic [7:0] e);
        #1;
        check({tag, ".strb"}, 32'(strb), 32'(s));
        check({tag, ".latch"}, 32'(reg_latch), 32'(l));
        check({tag, ".enable"}, 32'(reg_enable), 32'(e));
    endtask

    task automatic set_ir(input logic [3:0] op, input logic s, input logic [1:0] sh,
                          input logic [2:0] d1, input logic [2:0] d2,
                          input logic [2:0] s1, input logic [2:0] s2);
        opcode = op; S = s; shift = sh; rd_1 = d1; rd_2 = d2; rs_1 = s1; rs_2 = s2;
    endtask

    // Entered at the negedge of a FETCH0 cycle; leaves at the negedge of EX0.
    task automatic do_fetch(input string tag);
        exp_cyc({tag, ".f0"}, M_PC_OUT | M_MAR_IN, 8'h00, 8'h00);
        nxt();
        mem_ready = 1'b1;
        exp_cyc({tag, ".f1"}, M_MEM_RD | M_PC_INC, 8'h00, 8'h00);
        nxt();
        mem_ready = 1'b0;
        exp_cyc({tag, ".f2"}, M_MDR_OUT | M_IR_IN, 8'h00, 8'h00);
        nxt();
        exp_cyc({tag, ".dec"}, 16'h0000, 8'h00, 8'h00);
        nxt();
    endtask

    initial begin
        reset = 1'b0; mem_ready = 1'b0; flag_z = 1'b0; flag_n = 1'b0;
        set_ir(4'd0, 1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        nxt();
        exp_cyc("rst", 16'h0000, 8'h00, 8'h00);
        check("rst.alu_op", 32'(alu_op), 32'd0);
        nxt();

        // ADD r3 = r1 + r2, S=1, shift=2: seven cycles with an immediate fetch.
        reset = 1'b1;
        set_ir(4'd0, 1'b1, 2'd2, 3'd3, 3'd6, 3'd1, 3'd2);
        t0 = cyc;
        do_fetch("add");
        exp_cyc("add.ex0", M_Y_IN, 8'h00, 8'h02);
        nxt();
        exp_cyc("add.ex1", M_Z_IN | M_FLAGS, 8'h00, 8'h04);
        check("add.alu_op", 32'(alu_op), 32'd0);
        check("add.alu_shift", 32'(alu_shift), 32'd2);
        nxt();
        exp_cyc("add.ex2", M_Z_OUT, 8'h08, 8'h00);
        nxt();
        check("add.cycles", 32'(cyc - t0), 32'd7);

        // SUB interrupted by a 3-cycle reset in EX1.
        set_ir(4'd1, 1'b0, 2'd1, 3'd2, 3'd1, 3'd0, 3'd7);
        do_fetch("sub");
        exp_cyc("sub.ex0", M_Y_IN, 8'h00, 8'h01);
        nxt();
        exp_cyc("sub.ex1", M_Z_IN, 8'h00, 8'h80);
        check("sub.alu_op", 32'(alu_op), 32'd1);
        check("sub.alu_shift", 32'(alu_shift), 32'd1);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_cyc("rst_mid", 16'h0000, 8'h00, 8'h00);
            check("rst_mid.alu", 32'({alu_op, alu_shift}), 32'd0);
            nxt();
        end
        reset = 1'b1;

        // CMP: flags forced on with S=0, no destination latch.
        set_ir(4'd7, 1'b0, 2'd0, 3'd1, 3'd0, 3'd4, 3'd5);
        do_fetch("cmp");
        exp_cyc("cmp.ex0", M_Y_IN, 8'h00, 8'h10);
        nxt();
        exp_cyc("cmp.ex1", M_Z_IN | M_FLAGS, 8'h00, 8'h20);
        check("cmp.alu_op", 32'(alu_op), 32'd7);
        nxt();
        exp_cyc("cmp.ex2", M_Z_OUT, 8'h00, 8'h00);
        nxt();

        // LD r5 <- [r7] with mem_ready arriving on the fifth read cycle.
        set_ir(4'd9, 1'b1, 2'd1, 3'd0, 3'd5, 3'd0, 3'd7);
        do_fetch("ld");
        exp_cyc("ld.ex0", M_MAR_IN, 8'h00, 8'h80);
        nxt();
        for (int i = 0; i < 5; i++) begin
            mem_ready = (i == 4);
            exp_cyc("ld.wait", M_MEM_RD, 8'h00, 8'h00);
            nxt();
        end
        mem_ready = 1'b0;
        exp_cyc("ld.ex2", M_MDR_OUT, 8'h20, 8'h00);
        nxt();

        // LDI r2.
        set_ir(4'd8, 1'b0, 2'd2, 3'd0, 3'd2, 3'd0, 3'd0);
        do_fetch("ldi");
        exp_cyc("ldi.ex0", M_IMM_OUT, 8'h04, 8'h00);
        nxt();

        // BZ r3 not taken, then taken.
        set_ir(4'd12, 1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 3'd3);
        flag_z = 1'b0;
        do_fetch("bz0");
        exp_cyc("bz0.ex0", 16'h0000, 8'h00, 8'h00);
        nxt();
        flag_z = 1'b1;
        do_fetch("bz1");
        exp_cyc("bz1.ex0", M_PC_IN, 8'h00, 8'h08);
        nxt();
        flag_z = 1'b0;

        // BN r6 taken.
        set_ir(4'd13, 1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 3'd6);
        flag_n = 1'b1;
        do_fetch("bn");
        exp_cyc("bn.ex0", M_PC_IN, 8'h00, 8'h40);
        nxt();
        flag_n = 1'b0;

        // ST r4 -> [r1] with memory never ready: 15 write cycles, then sticky fault.
        set_ir(4'd10, 1'b1, 2'd0, 3'd0, 3'd4, 3'd0, 3'd1);
        do_fetch("st");
        exp_cyc("st.ex0", M_MAR_IN, 8'h00, 8'h02);
        nxt();
        exp_cyc("st.ex1", M_MDR_IN, 8'h00, 8'h10);
        nxt();
        for (int i = 0; i < 15; i++) begin
            exp_cyc("st.wait", M_MEM_WR, 8'h00, 8'h00);
            nxt();
        end
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 2);
            exp_cyc("st.fault", M_FAULT | M_HALT, 8'h00, 8'h00);
            nxt();
        end
        mem_ready = 1'b0;
        reset = 1'b0;
        exp_cyc("fault_rst", 16'h0000, 8'h00, 8'h00);
        nxt();
        reset = 1'b1;

        // HLT: halt holds regardless of mem_ready activity.
        set_ir(4'd15, 1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        do_fetch("hlt");
        exp_cyc("hlt.ex0", 16'h0000, 8'h00, 8'h00);
        nxt();
        for (int i = 0; i < 8; i++) begin
            mem_ready = i[0];
            exp_cyc("hlt.hold", M_HALT, 8'h00, 8'h00);
            nxt();
        end
        mem_ready = 1'b0;

        check("bus_excl", 32'(viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
